// File: rtl/microseq_ctrl.sv
// rtl/microseq_ctrl.sv - loadable micro-ROM control sequencer driving the DataPath control word
// Define MICROSEQ_MFC_TIMEOUT_EN to enable the MFC wait timeout and FAULT state.
module microseq_ctrl #(
  parameter int CW_W = 48,
  parameter int DEPTH = 64,
  parameter int DISP_W = 6,
  parameter int START_ADDR = 0,
  parameter logic [CW_W-1:0] CW_RST = '1,
  parameter int TO_CYC = 255,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = CW_W + AW + 3
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              run,
  input  logic              halt,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [IW-1:0]     ld_data,
  input  logic [DISP_W-1:0] disp_key,
  input  logic              cond,
  input  logic              mfc,
  output logic [CW_W-1:0]   cw,
  output logic [AW-1:0]     upc,
  output logic              waiting,
  output logic              ld_rej,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_DISP = 3'd2;
  localparam logic [2:0] OP_BRT  = 3'd3;
  localparam logic [2:0] OP_WMFC = 3'd4;
  localparam logic [2:0] OP_HLT  = 3'd5;

  state_t state;
  logic [IW-1:0] rom [DEPTH];

  logic [AW-1:0]   start_upc;
  logic [AW-1:0]   inc_upc;
  logic [AW-1:0]   next_upc;
  logic [AW-1:0]   cur_na;
  logic [2:0]      cur_op;
  logic [CW_W-1:0] start_cw;
  logic [CW_W-1:0] inc_cw;
  logic [CW_W-1:0] next_cw;

  assign start_upc = AW'(START_ADDR);
  assign inc_upc   = upc + 1'b1;
  assign cur_na    = rom[upc][CW_W+AW-1:CW_W];
  assign cur_op    = rom[upc][IW-1:CW_W+AW];
  assign start_cw  = rom[start_upc][CW_W-1:0];
  assign inc_cw    = rom[inc_upc][CW_W-1:0];
  assign next_cw   = rom[next_upc][CW_W-1:0];

  always_comb begin
    next_upc = inc_upc;
    case (cur_op)
      OP_JMP:  next_upc = cur_na;
      OP_DISP: next_upc = cur_na + AW'(disp_key);
      OP_BRT:  if (cond) next_upc = cur_na;
      default: next_upc = inc_upc;
    endcase
  end

  // Writes land only while HALT so the running program never changes under itself.
  always_ff @(posedge Clk) begin
    if (!Clr && ld_en && state == S_HALT) begin
      rom[ld_addr] <= ld_data;
    end
  end

`ifdef MICROSEQ_MFC_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  logic [15:0] unused_to_cyc;
  assign unused_to_cyc = 16'(TO_CYC);
  assign fault = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state   <= S_HALT;
      upc     <= '0;
      cw      <= CW_RST;
      waiting <= 1'b0;
      ld_rej  <= 1'b0;
`ifdef MICROSEQ_MFC_TIMEOUT_EN
      to_cnt  <= '0;
      fault   <= 1'b0;
`endif
    end else begin
      ld_rej <= ld_en && (state != S_HALT);
      case (state)
        S_HALT: begin
          if (run && !ld_en) begin
            state <= S_RUN;
            upc   <= start_upc;
            cw    <= start_cw;
          end
        end
        S_RUN: begin
          if (halt) begin
            state <= S_HALT;
            cw    <= CW_RST;
          end else begin
            case (cur_op)
              OP_WMFC: begin
                state   <= S_WAIT;
                waiting <= 1'b1;
`ifdef MICROSEQ_MFC_TIMEOUT_EN
                to_cnt  <= '0;
`endif
              end
              OP_HLT: begin
                state <= S_HALT;
                cw    <= CW_RST;
              end
              default: begin
                upc <= next_upc;
                cw  <= next_cw;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (halt) begin
            state   <= S_HALT;
            cw      <= CW_RST;
            waiting <= 1'b0;
          end else if (mfc) begin
            state   <= S_RUN;
            upc     <= inc_upc;
            cw      <= inc_cw;
            waiting <= 1'b0;
          end
`ifdef MICROSEQ_MFC_TIMEOUT_EN
          // mfc arriving in the timeout cycle is handled above and wins.
          else if (to_cnt == 16'(TO_CYC)) begin
            state   <= S_FAULT;
            cw      <= CW_RST;
            waiting <= 1'b0;
            fault   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        default: begin
          cw      <= CW_RST;
          waiting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb/tb_microseq_ctrl.sv - scoreboard bench for microseq_ctrl
// Timeout cases run only when MICROSEQ_MFC_TIMEOUT_EN is defined.
module tb_microseq_ctrl;

  localparam int CW_W = 16;
  localparam int AW = 6;
  localparam int IW = CW_W + AW + 3;
  localparam logic [15:0] RST = 16'hFFFF;
`ifdef MICROSEQ_MFC_TIMEOUT_EN
  localparam int WAIT_N = 3;
`else
  localparam int WAIT_N = 7;
`endif

  logic Clk = 1'b0;
  logic Clr, run, halt, ld_en, cond, mfc;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic [5:0] disp_key;
  logic [CW_W-1:0] cw;
  logic [AW-1:0] upc;
  logic waiting, ld_rej, fault;

  microseq_ctrl #(.CW_W(CW_W), .DEPTH(64), .DISP_W(6), .START_ADDR(0), .TO_CYC(4)) dut (
    .Clk(Clk), .Clr(Clr), .run(run), .halt(halt), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .disp_key(disp_key), .cond(cond), .mfc(mfc), .cw(cw), .upc(upc),
    .waiting(waiting), .ld_rej(ld_rej), .fault(fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    int cyc;
    logic [15:0] cw;
    int upc;
    logic w;
    logic f;
    logic r;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (cw !== e.cw || (e.upc >= 0 && upc !== AW'(e.upc)) ||
                   waiting !== e.w || fault !== e.f || ld_rej !== e.r) begin
        failures++;
        $display("FAIL %s: got cw=%h upc=%0d waiting=%b fault=%b ld_rej=%b, want cw=%h upc=%0d waiting=%b fault=%b ld_rej=%b",
                 e.name, cw, upc, waiting, fault, ld_rej, e.cw, e.upc, e.w, e.f, e.r);
      end
    end
  end

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [5:0] na, input logic [15:0] c);
    return {op, na, c};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step_expect(input string n, input logic [15:0] c, input int u,
                             input logic w, input logic f, input logic r);
    exp_t x;
    x.name = n; x.cyc = cyc + 1; x.cw = c; x.upc = u; x.w = w; x.f = f; x.r = r;
    sb.push_back(x);
    tick();
  endtask

  task automatic load(input logic [5:0] a, input logic [IW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    Clr = 1'b1; run = 0; halt = 0; ld_en = 0; cond = 0; mfc = 0;
    ld_addr = '0; ld_data = '0; disp_key = '0;
    tick();
    step_expect("reset", RST, 0, 0, 0, 0);
    Clr = 1'b0;

    load(0, mk(0, 0, 16'h0001)); load(1, mk(0, 0, 16'h0002));
    load(2, mk(0, 0, 16'h0003)); load(3, mk(5, 0, 16'h0004));
    load(4, mk(0, 0, 16'h0044)); load(5, mk(4, 0, 16'h0055)); load(6, mk(5, 0, 16'h0066));
    run = 1; step_expect("seq_cw1", 16'h0001, 0, 0, 0, 0); run = 0;
    step_expect("seq_cw2", 16'h0002, 1, 0, 0, 0);
    step_expect("seq_cw3", 16'h0003, 2, 0, 0, 0);
    step_expect("seq_cw4", 16'h0004, 3, 0, 0, 0);
    step_expect("seq_hlt", RST, 3, 0, 0, 0);
    step_expect("halt_keep_upc", RST, 3, 0, 0, 0);

    load(0, mk(1, 8, 16'h00A0)); load(8, mk(2, 16, 16'h0808)); load(20, mk(5, 0, 16'h0020));
    disp_key = 6'h04;
    run = 1; step_expect("disp_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("disp_jmp8", 16'h0808, 8, 0, 0, 0);
    step_expect("disp_20", 16'h0020, 20, 0, 0, 0);
    step_expect("disp_hlt", RST, 20, 0, 0, 0);

    load(8, mk(2, 60, 16'h0808)); disp_key = 6'h05;
    run = 1; step_expect("wrap_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("wrap_jmp8", 16'h0808, 8, 0, 0, 0);
    step_expect("wrap_to1", 16'h0002, 1, 0, 0, 0);
    step_expect("wrap_2", 16'h0003, 2, 0, 0, 0);
    step_expect("wrap_3", 16'h0004, 3, 0, 0, 0);
    step_expect("wrap_hlt", RST, 3, 0, 0, 0);

    load(0, mk(1, 2, 16'h00A0)); load(2, mk(3, 10, 16'h0003)); load(10, mk(5, 0, 16'h000A));
    cond = 0;
    run = 1; step_expect("brt0_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("brt0_at2", 16'h0003, 2, 0, 0, 0);
    step_expect("brt0_fall", 16'h0004, 3, 0, 0, 0);
    step_expect("brt0_hlt", RST, 3, 0, 0, 0);
    cond = 1;
    run = 1; step_expect("brt1_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("brt1_at2", 16'h0003, 2, 0, 0, 0);
    step_expect("brt1_taken", 16'h000A, 10, 0, 0, 0);
    step_expect("brt1_hlt", RST, 10, 0, 0, 0);
    cond = 0;

    load(0, mk(1, 63, 16'h00A0)); load(63, mk(1, 0, 16'h003F));
    run = 1; step_expect("jmp_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    ld_en = 1; ld_addr = 6'd5; ld_data = mk(5, 0, 16'h0BAD);
    step_expect("jmp_63_rej", 16'h003F, 63, 0, 0, 1); ld_en = 0;
    step_expect("jmp_wrap0", 16'h00A0, 0, 0, 0, 0);
    halt = 1; step_expect("halt_in_run", RST, 0, 0, 0, 0); halt = 0;

    load(0, mk(1, 4, 16'h00A0));
    run = 1; step_expect("w_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("w_at4", 16'h0044, 4, 0, 0, 0);
    step_expect("w_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    step_expect("w_enter", 16'h0055, 5, 1, 0, 0);
    for (int i = 1; i < WAIT_N; i++) step_expect("w_hold", 16'h0055, 5, 1, 0, 0);
    mfc = 1; step_expect("w_exit", 16'h0066, 6, 0, 0, 0); mfc = 0;
    step_expect("w_hlt", RST, 6, 0, 0, 0);

    run = 1; step_expect("we_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("we_at4", 16'h0044, 4, 0, 0, 0);
    mfc = 1;
    step_expect("we_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    step_expect("we_enter", 16'h0055, 5, 1, 0, 0);
    step_expect("we_exit", 16'h0066, 6, 0, 0, 0); mfc = 0;
    step_expect("we_hlt", RST, 6, 0, 0, 0);

    run = 1; step_expect("hm_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("hm_at4", 16'h0044, 4, 0, 0, 0);
    step_expect("hm_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    step_expect("hm_enter", 16'h0055, 5, 1, 0, 0);
    halt = 1; mfc = 1; step_expect("hm_halt_wins", RST, 5, 0, 0, 0); halt = 0; mfc = 0;
    step_expect("hm_halt_keep", RST, 5, 0, 0, 0);

`ifdef MICROSEQ_MFC_TIMEOUT_EN
    run = 1; step_expect("to_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("to_at4", 16'h0044, 4, 0, 0, 0);
    step_expect("to_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    step_expect("to_enter", 16'h0055, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) step_expect("to_hold", 16'h0055, 5, 1, 0, 0);
    step_expect("to_fault", RST, -1, 0, 1, 0);
    run = 1; step_expect("to_run_ignored", RST, -1, 0, 1, 0); run = 0;
    halt = 1; step_expect("to_halt_ignored", RST, -1, 0, 1, 0); halt = 0;
    Clr = 1; step_expect("to_clr", RST, 0, 0, 0, 0); Clr = 0;

    run = 1; step_expect("tm_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("tm_at4", 16'h0044, 4, 0, 0, 0);
    step_expect("tm_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    step_expect("tm_enter", 16'h0055, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) step_expect("tm_hold", 16'h0055, 5, 1, 0, 0);
    mfc = 1; step_expect("tm_mfc_wins", 16'h0066, 6, 0, 0, 0); mfc = 0;
    step_expect("tm_hlt", RST, 6, 0, 0, 0);
`else
    run = 1; step_expect("nt_start", 16'h00A0, 0, 0, 0, 0); run = 0;
    step_expect("nt_at4", 16'h0044, 4, 0, 0, 0);
    step_expect("nt_wmfc_cw", 16'h0055, 5, 0, 0, 0);
    for (int i = 0; i < 12; i++) step_expect("nt_hold", 16'h0055, 5, 1, 0, 0);
    halt = 1; step_expect("nt_halt", RST, 5, 0, 0, 0); halt = 0;
`endif

    run = 1; step_expect("clr_start", 16'h00A0, 0, 0, 0, 0);
    Clr = 1; ld_en = 1; ld_addr = 6'd0; ld_data = mk(5, 0, 16'h0BAD);
    step_expect("clr_override", RST, 0, 0, 0, 0);
    Clr = 0; ld_en = 0; run = 0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
